// File: rtl/ysyx_22040127_line_fill_bridge_pkg.sv
// rtl/ysyx_22040127_line_fill_bridge_pkg.sv - shared constants and state encoding for the line fill bridge
`ifndef CACHE_DATA_SIZE
`define CACHE_DATA_SIZE 128
`endif

package ysyx_22040127_line_fill_bridge_pkg;

    localparam int DEF_LINE_W = `CACHE_DATA_SIZE;
    localparam int DEF_BEAT_W = DEF_LINE_W / 2;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [7:0] AXI_LEN_2BEAT  = 8'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_BEAT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_RESP  = 3'd4,
        S_DROP  = 3'd5
    } fill_state_t;

endpackage

// File: rtl/ysyx_22040127_line_fill_bridge.sv
// rtl/ysyx_22040127_line_fill_bridge.sv - icache refill request to two-beat AXI4 read burst bridge
module ysyx_22040127_line_fill_bridge
    import ysyx_22040127_line_fill_bridge_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         LINE_W = DEF_LINE_W,
    parameter int         BEAT_W = DEF_BEAT_W,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       req_addr,
    input  logic              req_valid,
    output logic              res_valid,
    output logic [LINE_W-1:0] res_data,
    output logic              res_err,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [BEAT_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    fill_state_t state;
    logic        err;

    // Only the line-address field of the request is meaningful.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[63:ADDR_W], req_addr[3:0]};

    // Burst shape never changes: one 2-beat INCR burst of 8-byte beats per line.
    assign arid    = AXI_ID;
    assign arlen   = AXI_LEN_2BEAT;
    assign arsize  = AXI_SIZE_8B;
    assign arburst = AXI_BURST_INCR;

    // Request/burst sequencer with registered AXI handshakes and response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_data  <= '0;
            araddr    <= '0;
            err       <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        araddr  <= {req_addr[ADDR_W-1:4], 4'b0000};
                        err     <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= S_AR;
                    end
                end
                S_AR: begin
                    // Once raised, AR stays up until accepted, whatever the cache does.
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (rvalid && rready) begin
                        res_data[BEAT_W-1:0] <= rdata;
                        err   <= err | (rresp != AXI_RESP_OKAY) | rlast;
                        state <= S_BEAT1;
                    end
                end
                S_BEAT1: begin
                    if (rvalid && rready) begin
                        res_data[LINE_W-1:BEAT_W] <= rdata;
                        res_err   <= err | (rresp != AXI_RESP_OKAY) | ~rlast;
                        rready    <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_DROP;
                end
                S_DROP: begin
                    // The level request is still the one just served until it drops.
                    if (!req_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040127_line_fill_bridge.sv
// tb/tb_ysyx_22040127_line_fill_bridge.sv - randomized self-checking bench for the line fill bridge
module tb_ysyx_22040127_line_fill_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  req_addr;
    logic         req_valid;
    logic         res_valid;
    logic [127:0] res_data;
    logic         res_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int checks   = 0;
    int failures = 0;

    ysyx_22040127_line_fill_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (req_addr),
        .req_valid (req_valid),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_err   (res_err),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [63:0] addr, input int ar_delay, input int gap,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input logic [1:0] r0, input logic [1:0] r1,
                           input logic l0, input logic l1, input int hold);
        logic [31:0]  exp_addr;
        logic [127:0] exp_line;
        logic         exp_err;
        int           t;
        int           n;
        exp_addr = addr[31:0] & 32'hFFFF_FFF0;
        exp_line = {d1, d0};
        exp_err  = (r0 != 2'b00) || (r1 != 2'b00) || l0 || !l1;

        req_addr  = addr;
        req_valid = 1'b1;
        t = 0;
        tick(); t++;
        chk("arvalid_up", arvalid, 1'b1);
        chk("araddr", araddr, exp_addr);
        chk("ar_const", {arid, arlen, arsize, arburst}, {4'd0, 8'd1, 3'd3, 2'd1});
        chk("rready_pre_ar", rready, 1'b0);
        for (int k = 0; k < ar_delay; k++) begin
            arready  = 1'b0;
            req_addr = {$urandom, $urandom};
            rvalid   = $urandom_range(0, 1);
            rdata    = {$urandom, $urandom};
            rlast    = 1'b1;
            tick(); t++;
            chk("ar_hold_valid", arvalid, 1'b1);
            chk("ar_hold_addr", araddr, exp_addr);
            chk("ar_hold_rready", rready, 1'b0);
        end
        rvalid  = 1'b0;
        arready = 1'b1;
        tick(); t++;
        arready = 1'b0;
        chk("ar_done_valid", arvalid, 1'b0);
        chk("ar_done_rready", rready, 1'b1);
        rvalid = 1'b1; rdata = d0; rresp = r0; rlast = l0;
        tick(); t++;
        for (int k = 0; k < gap; k++) begin
            rvalid   = 1'b0;
            rdata    = {$urandom, $urandom};
            rlast    = $urandom_range(0, 1);
            rresp    = 2'($urandom);
            req_addr = {$urandom, $urandom};
            tick(); t++;
            chk("gap_no_res", res_valid, 1'b0);
        end
        rvalid = 1'b1; rdata = d1; rresp = r1; rlast = l1;
        n = 0;
        do begin
            tick(); t++; n++;
            rvalid = 1'b0;
        end while (!res_valid && n < 20);
        chk("res_valid", res_valid, 1'b1);
        chk("latency", t, 4 + ar_delay + gap);
        chk("res_data", res_data, exp_line);
        chk("res_err", res_err, exp_err);
        chk("rready_after", rready, 1'b0);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("held_no_ar", arvalid, 1'b0);
            if (k == 0) chk("pulse_once", res_valid, 1'b0);
        end
        req_valid = 1'b0;
        tick();
        if (hold == 0) chk("pulse_once", res_valid, 1'b0);
        chk("drop_no_ar", arvalid, 1'b0);
        chk("data_hold", res_data, exp_line);
        tick();
    endtask

    initial begin
        rst = 1'b1; req_addr = '0; req_valid = 1'b0; arready = 1'b0;
        rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        tick(); tick();
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_err", res_err, 1'b0);
        chk("rst_res_data", res_data, 128'd0);
        chk("rst_araddr", araddr, 32'd0);
        rst = 1'b0;
        tick();

        run_txn(64'h0000_0000_8000_0128, 0, 0, 64'h1111, 64'h2222, 2'b00, 2'b00, 1'b0, 1'b1, 0);
        run_txn(64'hDEAD_BEEF_1234_567F, 5, 0, 64'hA5A5_0000_1111_2222, 64'h5A5A_3333_4444_5555,
                2'b00, 2'b00, 1'b0, 1'b1, 0);
        run_txn(64'h0000_0000_0000_0008, 0, 3, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                2'b00, 2'b00, 1'b0, 1'b1, 4);
        run_txn(64'h0000_0000_8000_0040, 1, 1, 64'h77, 64'h88, 2'b00, 2'b10, 1'b0, 1'b1, 0);
        run_txn(64'h0000_0000_8000_0050, 0, 0, 64'h99, 64'hAA, 2'b00, 2'b00, 1'b1, 1'b1, 0);
        run_txn(64'h0000_0000_8000_0060, 0, 0, 64'hBB, 64'hCC, 2'b00, 2'b00, 1'b0, 1'b0, 0);

        // reset while waiting for the second beat
        req_addr = 64'h0000_0000_8000_0300; req_valid = 1'b1;
        tick();
        arready = 1'b1; tick(); arready = 1'b0;
        rvalid = 1'b1; rdata = 64'hFFFF; rresp = 2'b00; rlast = 1'b0;
        tick();
        rvalid = 1'b0; rst = 1'b1; req_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_arvalid", arvalid, 1'b0);
        chk("midrst_rready", rready, 1'b0);
        chk("midrst_res_valid", res_valid, 1'b0);
        chk("midrst_res_data", res_data, 128'd0);
        tick();
        run_txn(64'h0000_0000_8000_0310, 0, 0, 64'h1234, 64'h5678, 2'b00, 2'b00, 1'b0, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] r0;
            logic [1:0] r1;
            logic       l0;
            logic       l1;
            r0 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r1 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            l0 = ($urandom_range(0, 5) == 0);
            l1 = ($urandom_range(0, 5) != 0);
            run_txn({$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, 3),
                    {$urandom, $urandom}, {$urandom, $urandom}, r0, r1, l0, l1,
                    $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
